// File: rtl/vex_bus_pkg.sv
// Shared types for the VexRiscv iBus/dBus to memory arbiter.
// No logic of its own; the tag entry type and beat-count helper live here.
// Backpressure: n/a.
package vex_bus_pkg;

   typedef enum logic {
      SRC_IBUS = 1'b0,
      SRC_DBUS = 1'b1
   } src_e;

   // One outstanding read: who asked, and how many response beats to expect.
   typedef struct packed {
      src_e       src;
      logic [3:0] beats;
   } outst_t;

   // Response beats for a read of 2^size bytes on a bpb-byte bus.
   // Sub-beat reads still return one beat; anything past a line of 8 beats
   // is clipped.
   function automatic logic [3:0] beats_of(input logic [2:0] size, input int bpb);
      int n;
      n = (1 << size) / bpb;
      if (n < 1) begin
         n = 1;
      end else if (n > 8) begin
         n = 8;
      end
      return n[3:0];
   endfunction

endpackage

// File: rtl/vex_bus_tag_fifo.sv
// Tag FIFO of outstanding reads; head entry is visible combinationally.
// Latency: push visible at head the cycle after; pop is immediate.
// Backpressure: a push while full is dropped unless a pop frees a slot the same cycle.
// Ports: clk/reset (sync, active-low); i_push/i_push_dat write side;
//        i_pop read side; o_head_dat, o_full, o_empty, o_count status.
module vex_bus_tag_fifo
   import vex_bus_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  outst_t           i_push_dat,
   input  logic             i_pop,
   output outst_t           o_head_dat,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   outst_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full     = (r_count == FULL_CNT);
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_head_dat = r_mem[r_rd_ptr];

   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/vex_bus_arbiter.sv
// Merges VexRiscv iBus and dBus onto one memory port and routes read beats back.
// Latency: zero on both the command and the response path.
// Backpressure: mem_cmd_ready passes to the granted requester; reads stall when MAX_OUTSTANDING are in flight.
// Ports: clk/reset (sync, active-low); ibus_cmd_*/ibus_rsp_* iBus side;
//        dbus_cmd_*/dbus_rsp_* dBus side; mem_cmd_* shared command (mem_cmd_src tags
//        the requester); mem_rsp_* in-order read beats, never backpressured.
module vex_bus_arbiter
   import vex_bus_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                clk,
   input  logic                reset,
   // iBus
   input  logic                ibus_cmd_valid,
   output logic                ibus_cmd_ready,
   input  logic [ADDR_W-1:0]   ibus_cmd_address,
   input  logic [2:0]          ibus_cmd_size,
   output logic                ibus_rsp_valid,
   output logic [DATA_W-1:0]   ibus_rsp_data,
   output logic                ibus_rsp_error,
   // dBus
   input  logic                dbus_cmd_valid,
   output logic                dbus_cmd_ready,
   input  logic                dbus_cmd_wr,
   input  logic                dbus_cmd_uncached,
   input  logic                dbus_cmd_last,
   input  logic [ADDR_W-1:0]   dbus_cmd_address,
   input  logic [DATA_W-1:0]   dbus_cmd_data,
   input  logic [DATA_W/8-1:0] dbus_cmd_mask,
   input  logic [2:0]          dbus_cmd_size,
   output logic                dbus_rsp_valid,
   output logic                dbus_rsp_last,
   output logic                dbus_rsp_error,
   output logic [DATA_W-1:0]   dbus_rsp_data,
   // memory
   output logic                mem_cmd_valid,
   input  logic                mem_cmd_ready,
   output logic                mem_cmd_wr,
   output logic                mem_cmd_uncached,
   output logic                mem_cmd_last,
   output logic [ADDR_W-1:0]   mem_cmd_address,
   output logic [DATA_W-1:0]   mem_cmd_data,
   output logic [DATA_W/8-1:0] mem_cmd_mask,
   output logic [2:0]          mem_cmd_size,
   output logic                mem_cmd_src,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_data,
   input  logic                mem_rsp_error
);

   localparam int BPB   = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

   src_e             r_last_grant;
   src_e             r_hold_src;
   logic             r_hold;
   logic             r_lock;
   logic [2:0]       r_beat_cnt;

   src_e             w_grant;
   logic             w_gnt_ibus;
   logic             w_gnt_vld;
   logic             w_is_read;
   logic             w_block;
   logic             w_accept;
   logic             w_push;
   outst_t           w_push_dat;
   outst_t           w_head;
   logic             w_empty;
   logic             w_unused_full;
   logic [CNT_W-1:0] w_count;
   logic             w_rsp_vld;
   logic             w_head_last;
   logic             w_pop;

   logic                w_cmd_wr;
   logic                w_cmd_uncached;
   logic                w_cmd_last;
   logic [ADDR_W-1:0]   w_cmd_address;
   logic [DATA_W-1:0]   w_cmd_data;
   logic [DATA_W/8-1:0] w_cmd_mask;
   logic [2:0]          w_cmd_size;

   // A stalled command keeps its grant; an open write burst keeps dBus.
   // Otherwise a tie goes to whoever did not finish the last transfer.
   always_comb begin
      w_grant = SRC_DBUS;
      if (r_hold) begin
         w_grant = r_hold_src;
      end else if (r_lock) begin
         w_grant = SRC_DBUS;
      end else if (ibus_cmd_valid && dbus_cmd_valid) begin
         w_grant = (r_last_grant == SRC_IBUS) ? SRC_DBUS : SRC_IBUS;
      end else if (ibus_cmd_valid) begin
         w_grant = SRC_IBUS;
      end
   end

   assign w_gnt_ibus = (w_grant == SRC_IBUS);

   // iBus only ever issues full-mask cached single reads.
   always_comb begin
      w_cmd_wr       = 1'b0;
      w_cmd_uncached = 1'b0;
      w_cmd_last     = 1'b1;
      w_cmd_address  = ibus_cmd_address;
      w_cmd_data     = '0;
      w_cmd_mask     = '1;
      w_cmd_size     = ibus_cmd_size;
      if (!w_gnt_ibus) begin
         w_cmd_wr       = dbus_cmd_wr;
         w_cmd_uncached = dbus_cmd_uncached;
         w_cmd_last     = dbus_cmd_last;
         w_cmd_address  = dbus_cmd_address;
         w_cmd_data     = dbus_cmd_data;
         w_cmd_mask     = dbus_cmd_mask;
         w_cmd_size     = dbus_cmd_size;
      end
   end

   assign w_gnt_vld = w_gnt_ibus ? ibus_cmd_valid : dbus_cmd_valid;
   assign w_is_read = ~w_cmd_wr;
   // Registered count only: a pop this cycle does not free a slot until next cycle.
   assign w_block   = w_is_read & (w_count == FULL_CNT);

   assign mem_cmd_valid    = reset & w_gnt_vld & ~w_block;
   assign mem_cmd_wr       = w_cmd_wr;
   assign mem_cmd_uncached = w_cmd_uncached;
   assign mem_cmd_last     = w_cmd_last;
   assign mem_cmd_address  = w_cmd_address;
   assign mem_cmd_data     = w_cmd_data;
   assign mem_cmd_mask     = w_cmd_mask;
   assign mem_cmd_size     = w_cmd_size;
   assign mem_cmd_src      = w_grant;

   assign ibus_cmd_ready = reset &  w_gnt_ibus & mem_cmd_ready & ~w_block;
   assign dbus_cmd_ready = reset & ~w_gnt_ibus & mem_cmd_ready & ~w_block;

   assign w_accept   = mem_cmd_valid & mem_cmd_ready;
   assign w_push     = w_accept & w_is_read;
   assign w_push_dat = '{src: w_grant, beats: beats_of(w_cmd_size, BPB)};

   vex_bus_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .o_head_dat (w_head),
      .o_full     (w_unused_full),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

   // Beats with nothing outstanding are stray and dropped.
   assign w_rsp_vld   = reset & mem_rsp_valid & ~w_empty;
   assign w_head_last = ({1'b0, r_beat_cnt} == (w_head.beats - 4'd1));
   assign w_pop       = w_rsp_vld & w_head_last;

   assign ibus_rsp_valid = w_rsp_vld & (w_head.src == SRC_IBUS);
   assign ibus_rsp_data  = mem_rsp_data;
   assign ibus_rsp_error = mem_rsp_error;
   assign dbus_rsp_valid = w_rsp_vld & (w_head.src == SRC_DBUS);
   assign dbus_rsp_last  = dbus_rsp_valid & w_head_last;
   assign dbus_rsp_data  = mem_rsp_data;
   assign dbus_rsp_error = mem_rsp_error;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last_grant <= SRC_DBUS;
         r_hold_src   <= SRC_IBUS;
         r_hold       <= 1'b0;
         r_lock       <= 1'b0;
         r_beat_cnt   <= '0;
      end else begin
         r_hold     <= mem_cmd_valid & ~mem_cmd_ready;
         r_hold_src <= w_grant;
         if (w_accept) begin
            if (!w_gnt_ibus && w_cmd_wr) begin
               r_lock <= ~w_cmd_last;
            end
            if (w_cmd_last) begin
               r_last_grant <= w_grant;
            end
         end
         if (w_pop) begin
            r_beat_cnt <= '0;
         end else if (w_rsp_vld) begin
            r_beat_cnt <= r_beat_cnt + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_vex_bus_arbiter.sv
module tb_vex_bus_arbiter;

   localparam int MAXO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        ibus_cmd_valid, ibus_cmd_ready;
   logic [31:0] ibus_cmd_address;
   logic [2:0]  ibus_cmd_size;
   logic        ibus_rsp_valid, ibus_rsp_error;
   logic [31:0] ibus_rsp_data;
   logic        dbus_cmd_valid, dbus_cmd_ready, dbus_cmd_wr, dbus_cmd_uncached, dbus_cmd_last;
   logic [31:0] dbus_cmd_address, dbus_cmd_data;
   logic [3:0]  dbus_cmd_mask;
   logic [2:0]  dbus_cmd_size;
   logic        dbus_rsp_valid, dbus_rsp_last, dbus_rsp_error;
   logic [31:0] dbus_rsp_data;
   logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_wr, mem_cmd_uncached, mem_cmd_last, mem_cmd_src;
   logic [31:0] mem_cmd_address, mem_cmd_data;
   logic [3:0]  mem_cmd_mask;
   logic [2:0]  mem_cmd_size;
   logic        mem_rsp_valid, mem_rsp_error;
   logic [31:0] mem_rsp_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vex_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .reset(reset),
      .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready),
      .ibus_cmd_address(ibus_cmd_address), .ibus_cmd_size(ibus_cmd_size),
      .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_data(ibus_rsp_data), .ibus_rsp_error(ibus_rsp_error),
      .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
      .dbus_cmd_wr(dbus_cmd_wr), .dbus_cmd_uncached(dbus_cmd_uncached), .dbus_cmd_last(dbus_cmd_last),
      .dbus_cmd_address(dbus_cmd_address), .dbus_cmd_data(dbus_cmd_data),
      .dbus_cmd_mask(dbus_cmd_mask), .dbus_cmd_size(dbus_cmd_size),
      .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_last(dbus_rsp_last),
      .dbus_rsp_error(dbus_rsp_error), .dbus_rsp_data(dbus_rsp_data),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_wr(mem_cmd_wr), .mem_cmd_uncached(mem_cmd_uncached), .mem_cmd_last(mem_cmd_last),
      .mem_cmd_address(mem_cmd_address), .mem_cmd_data(mem_cmd_data),
      .mem_cmd_mask(mem_cmd_mask), .mem_cmd_size(mem_cmd_size), .mem_cmd_src(mem_cmd_src),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_error(mem_rsp_error)
   );

   // ---------------- reference model ----------------
   // Outstanding reads as a queue of (requester, beats); beats taken from head.
   logic m_last;       // requester that finished the last transfer
   logic m_lock;
   logic m_hold;
   logic m_hold_src;
   int   m_beat;
   logic q_src[$];
   int   q_beats[$];

   logic        e_gnt, e_mvld, e_irdy, e_drdy, e_irsp, e_drsp, e_dlast;
   logic [75:0] e_cmd;  // {src, wr, uncached, last, address, data, mask, size}

   function automatic int model_beats(input logic [2:0] size);
      int bytes;
      int n;
      bytes = 1;
      for (int i = 0; i < int'(size); i++) bytes = bytes * 2;
      n = bytes / 4;
      if (n < 1) n = 1;
      if (n > 8) n = 8;
      return n;
   endfunction

   function void model_eval();
      logic rd;
      logic blk;
      e_mvld = 0; e_irdy = 0; e_drdy = 0; e_irsp = 0; e_drsp = 0; e_dlast = 0;
      if (m_hold)                                e_gnt = m_hold_src;
      else if (m_lock)                           e_gnt = 1'b1;
      else if (ibus_cmd_valid && dbus_cmd_valid) e_gnt = ~m_last;
      else if (ibus_cmd_valid)                   e_gnt = 1'b0;
      else                                       e_gnt = 1'b1;
      rd  = (e_gnt == 1'b0) || !dbus_cmd_wr;
      blk = rd && (q_src.size() == MAXO);
      if (e_gnt == 1'b0)
         e_cmd = {1'b0, 1'b0, 1'b0, 1'b1, ibus_cmd_address, 32'h0, 4'hf, ibus_cmd_size};
      else
         e_cmd = {1'b1, dbus_cmd_wr, dbus_cmd_uncached, dbus_cmd_last, dbus_cmd_address,
                  dbus_cmd_data, dbus_cmd_mask, dbus_cmd_size};
      if (reset) begin
         e_mvld = ((e_gnt == 1'b0) ? ibus_cmd_valid : dbus_cmd_valid) && !blk;
         e_irdy = (e_gnt == 1'b0) && mem_cmd_ready && !blk;
         e_drdy = (e_gnt == 1'b1) && mem_cmd_ready && !blk;
         if (mem_rsp_valid && q_src.size() > 0) begin
            if (q_src[0] == 1'b0) e_irsp = 1;
            else begin
               e_drsp  = 1;
               e_dlast = (m_beat + 1 == q_beats[0]);
            end
         end
      end
   endfunction

   function void model_commit();
      logic rd;
      if (!reset) begin
         q_src.delete(); q_beats.delete();
         m_beat = 0; m_lock = 0; m_hold = 0; m_hold_src = 0; m_last = 1'b1;
         return;
      end
      if (mem_rsp_valid && q_src.size() > 0) begin
         m_beat++;
         if (m_beat == q_beats[0]) begin
            void'(q_src.pop_front());
            void'(q_beats.pop_front());
            m_beat = 0;
         end
      end
      m_hold     = e_mvld && !mem_cmd_ready;
      m_hold_src = e_gnt;
      if (e_mvld && mem_cmd_ready) begin
         rd = (e_gnt == 1'b0) || !dbus_cmd_wr;
         if (e_gnt == 1'b1 && dbus_cmd_wr) m_lock = !dbus_cmd_last;
         if (e_gnt == 1'b0 || dbus_cmd_last) m_last = e_gnt;
         if (rd) begin
            q_src.push_back(e_gnt);
            q_beats.push_back(model_beats((e_gnt == 1'b0) ? ibus_cmd_size : dbus_cmd_size));
         end
      end
   endfunction

   // ---------------- stimulus plumbing ----------------
   task automatic to_neg();
      @(negedge clk);
      model_eval();
   endtask

   task automatic to_next();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ibus_cmd_valid = 0; ibus_cmd_address = '0; ibus_cmd_size = 3'd2;
      dbus_cmd_valid = 0; dbus_cmd_wr = 0; dbus_cmd_uncached = 0; dbus_cmd_last = 1;
      dbus_cmd_address = '0; dbus_cmd_data = '0; dbus_cmd_mask = 4'hf; dbus_cmd_size = 3'd2;
      mem_cmd_ready = 1; mem_rsp_valid = 0; mem_rsp_data = '0; mem_rsp_error = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 0;
      repeat (2) begin to_neg(); to_next(); end
      reset = 1;
   endtask

   // One single-beat iBus read, accepted and answered; leaves iBus as last grant.
   task automatic ibus_read_and_drain();
      ibus_cmd_valid = 1; ibus_cmd_address = 32'h100; ibus_cmd_size = 3'd2;
      to_neg(); to_next();
      ibus_cmd_valid = 0; mem_rsp_valid = 1;
      to_neg(); to_next();
      mem_rsp_valid = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      reset = 0;
      ibus_cmd_valid = 1; dbus_cmd_valid = 1; mem_rsp_valid = 1;
      repeat (2) begin
         to_neg();
         n_vec++;
         if ({mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready, ibus_rsp_valid, dbus_rsp_valid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready, ibus_rsp_valid, dbus_rsp_valid});
         end
         to_next();
      end
      reset = 1;
      idle();
   endtask

   task automatic test_single_read();
      int ni = 0;
      int nd = 0;
      do_reset();
      ibus_cmd_valid = 1; ibus_cmd_address = 32'h8000_0000; ibus_cmd_size = 3'd5;
      to_neg();
      n_vec++;
      if ({mem_cmd_valid, mem_cmd_src, ibus_cmd_ready} !== 3'b101 || mem_cmd_address !== 32'h8000_0000) begin
         n_err++;
         $display("FAIL single_cmd: got v/src/rdy=%b addr=%h want 101 80000000",
                  {mem_cmd_valid, mem_cmd_src, ibus_cmd_ready}, mem_cmd_address);
      end
      to_next();
      ibus_cmd_valid = 0;
      for (int k = 0; k < 8; k++) begin
         mem_rsp_valid = 1; mem_rsp_data = 32'hA000_0000 + k;
         to_neg();
         if (ibus_rsp_valid) ni++;
         if (dbus_rsp_valid) nd++;
         n_vec++;
         if (ibus_rsp_data !== 32'hA000_0000 + k) begin
            n_err++;
            $display("FAIL single_data: got %h want %h", ibus_rsp_data, 32'hA000_0000 + k);
         end
         to_next();
      end
      n_vec++;
      if (ni != 8 || nd != 0) begin
         n_err++;
         $display("FAIL single_beats: got ibus=%0d dbus=%0d want 8 0", ni, nd);
      end
      to_neg();
      n_vec++;
      if ({ibus_rsp_valid, dbus_rsp_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL single_empty: got %b want 00", {ibus_rsp_valid, dbus_rsp_valid});
      end
      to_next();
      idle();
   endtask

   task automatic test_tie();
      do_reset();
      ibus_cmd_valid = 1; ibus_cmd_address = 32'h10; ibus_cmd_size = 3'd2;
      dbus_cmd_valid = 1; dbus_cmd_wr = 0; dbus_cmd_last = 1; dbus_cmd_address = 32'h200; dbus_cmd_size = 3'd2;
      to_neg();
      n_vec++;
      if ({mem_cmd_src, ibus_cmd_ready, dbus_cmd_ready} !== 3'b010) begin
         n_err++;
         $display("FAIL tie_cycle0: got src/irdy/drdy=%b want 010", {mem_cmd_src, ibus_cmd_ready, dbus_cmd_ready});
      end
      to_next();
      ibus_cmd_valid = 0;
      to_neg();
      n_vec++;
      if ({mem_cmd_src, dbus_cmd_ready, mem_cmd_address} !== {2'b11, 32'h200}) begin
         n_err++;
         $display("FAIL tie_cycle1: got src/drdy=%b addr=%h want 11 200",
                  {mem_cmd_src, dbus_cmd_ready}, mem_cmd_address);
      end
      to_next();
      dbus_cmd_valid = 0;
      mem_rsp_valid = 1; mem_rsp_data = 32'h1111_1111;
      to_neg();
      n_vec++;
      if ({ibus_rsp_valid, dbus_rsp_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL tie_rsp_i: got i/d=%b want 10", {ibus_rsp_valid, dbus_rsp_valid});
      end
      to_next();
      mem_rsp_data = 32'h2222_2222;
      to_neg();
      n_vec++;
      if ({ibus_rsp_valid, dbus_rsp_valid, dbus_rsp_last} !== 3'b011 || dbus_rsp_data !== 32'h2222_2222) begin
         n_err++;
         $display("FAIL tie_rsp_d: got i/d/last=%b data=%h want 011 22222222",
                  {ibus_rsp_valid, dbus_rsp_valid, dbus_rsp_last}, dbus_rsp_data);
      end
      to_next();
      idle();
   endtask

   task automatic test_write_lock();
      int ni = 0;
      int nd = 0;
      do_reset();
      ibus_read_and_drain();
      for (int k = 0; k < 4; k++) begin
         ibus_cmd_valid = 1; ibus_cmd_address = 32'h300; ibus_cmd_size = 3'd2;
         dbus_cmd_valid = 1; dbus_cmd_wr = 1; dbus_cmd_last = (k == 3);
         dbus_cmd_address = 32'h400 + 4 * k; dbus_cmd_data = 32'hD0 + k; dbus_cmd_mask = 4'h3;
         to_neg();
         n_vec++;
         if ({mem_cmd_src, dbus_cmd_ready, ibus_cmd_ready} !== 3'b110 || mem_cmd_data !== 32'hD0 + k) begin
            n_err++;
            $display("FAIL lock_beat%0d: got src/drdy/irdy=%b data=%h want 110 %h",
                     k, {mem_cmd_src, dbus_cmd_ready, ibus_cmd_ready}, mem_cmd_data, 32'hD0 + k);
         end
         to_next();
      end
      dbus_cmd_valid = 0;
      to_neg();
      n_vec++;
      if ({mem_cmd_src, ibus_cmd_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL lock_release: got src/irdy=%b want 01", {mem_cmd_src, ibus_cmd_ready});
      end
      to_next();
      ibus_cmd_valid = 0;
      mem_rsp_valid = 1;
      repeat (2) begin
         to_neg();
         if (ibus_rsp_valid) ni++;
         if (dbus_rsp_valid) nd++;
         to_next();
      end
      n_vec++;
      if (ni != 1 || nd != 0) begin
         n_err++;
         $display("FAIL lock_no_wr_rsp: got ibus=%0d dbus=%0d want 1 0", ni, nd);
      end
      idle();
   endtask

   task automatic test_outstanding();
      int ni = 0;
      int nd = 0;
      do_reset();
      ibus_cmd_valid = 1; ibus_cmd_size = 3'd2;
      for (int k = 0; k < 4; k++) begin
         ibus_cmd_address = 32'h40 + 4 * k;
         to_neg();
         n_vec++;
         if (ibus_cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL outst_fill%0d: got irdy=%b want 1", k, ibus_cmd_ready);
         end
         to_next();
      end
      dbus_cmd_valid = 1; dbus_cmd_wr = 0; dbus_cmd_last = 1; dbus_cmd_size = 3'd2; dbus_cmd_address = 32'h600;
      to_neg();
      n_vec++;
      if ({ibus_cmd_ready, dbus_cmd_ready, mem_cmd_valid} !== 3'b000) begin
         n_err++;
         $display("FAIL outst_full: got irdy/drdy/mvld=%b want 000", {ibus_cmd_ready, dbus_cmd_ready, mem_cmd_valid});
      end
      to_next();
      mem_rsp_valid = 1;
      to_neg();
      n_vec++;
      if ({ibus_cmd_ready, dbus_cmd_ready, ibus_rsp_valid} !== 3'b001) begin
         n_err++;
         $display("FAIL outst_no_credit: got irdy/drdy/irsp=%b want 001", {ibus_cmd_ready, dbus_cmd_ready, ibus_rsp_valid});
      end
      to_next();
      mem_rsp_valid = 0;
      to_neg();
      n_vec++;
      if ({mem_cmd_src, dbus_cmd_ready} !== 2'b11) begin
         n_err++;
         $display("FAIL outst_reopen: got src/drdy=%b want 11", {mem_cmd_src, dbus_cmd_ready});
      end
      to_next();
      ibus_cmd_valid = 0; dbus_cmd_valid = 0; mem_rsp_valid = 1;
      repeat (4) begin
         to_neg();
         if (ibus_rsp_valid) ni++;
         if (dbus_rsp_valid) nd++;
         to_next();
      end
      n_vec++;
      if (ni != 3 || nd != 1) begin
         n_err++;
         $display("FAIL outst_drain: got ibus=%0d dbus=%0d want 3 1", ni, nd);
      end
      idle();
   endtask

   task automatic test_hold();
      do_reset();
      ibus_read_and_drain();
      ibus_cmd_valid = 1; ibus_cmd_address = 32'h0000_1230; ibus_cmd_size = 3'd2;
      mem_cmd_ready = 0;
      to_neg();
      n_vec++;
      if ({mem_cmd_valid, mem_cmd_src, ibus_cmd_ready} !== 3'b100) begin
         n_err++;
         $display("FAIL hold_c0: got mvld/src/irdy=%b want 100", {mem_cmd_valid, mem_cmd_src, ibus_cmd_ready});
      end
      to_next();
      dbus_cmd_valid = 1; dbus_cmd_wr = 0; dbus_cmd_last = 1; dbus_cmd_address = 32'h500;
      for (int c = 1; c < 3; c++) begin
         to_neg();
         n_vec++;
         if ({mem_cmd_valid, mem_cmd_src} !== 2'b10 || mem_cmd_address !== 32'h0000_1230) begin
            n_err++;
            $display("FAIL hold_c%0d: got mvld/src=%b addr=%h want 10 00001230",
                     c, {mem_cmd_valid, mem_cmd_src}, mem_cmd_address);
         end
         to_next();
      end
      mem_cmd_ready = 1;
      to_neg();
      n_vec++;
      if ({mem_cmd_src, ibus_cmd_ready, dbus_cmd_ready} !== 3'b010) begin
         n_err++;
         $display("FAIL hold_accept: got src/irdy/drdy=%b want 010", {mem_cmd_src, ibus_cmd_ready, dbus_cmd_ready});
      end
      to_next();
      ibus_cmd_valid = 0;
      to_neg();
      n_vec++;
      if ({mem_cmd_src, dbus_cmd_ready} !== 2'b11) begin
         n_err++;
         $display("FAIL hold_next: got src/drdy=%b want 11", {mem_cmd_src, dbus_cmd_ready});
      end
      to_next();
      dbus_cmd_valid = 0; mem_rsp_valid = 1;
      repeat (2) begin to_neg(); to_next(); end
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      ibus_cmd_valid = 1; ibus_cmd_address = 32'h8000_0000; ibus_cmd_size = 3'd5;
      to_neg(); to_next();
      ibus_cmd_valid = 0; mem_rsp_valid = 1;
      repeat (2) begin to_neg(); to_next(); end
      reset = 0; ibus_cmd_valid = 1;
      to_neg();
      n_vec++;
      if ({mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready, ibus_rsp_valid, dbus_rsp_valid} !== 5'b0) begin
         n_err++;
         $display("FAIL midrst_outputs: got %b want 00000",
                  {mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready, ibus_rsp_valid, dbus_rsp_valid});
      end
      to_next();
      reset = 1; ibus_cmd_valid = 0;
      for (int k = 0; k < 3; k++) begin
         to_neg();
         n_vec++;
         if ({ibus_rsp_valid, dbus_rsp_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL midrst_stray%0d: got %b want 00", k, {ibus_rsp_valid, dbus_rsp_valid});
         end
         to_next();
      end
      mem_rsp_valid = 0;
      ibus_cmd_valid = 1; ibus_cmd_address = 32'h20; ibus_cmd_size = 3'd2;
      to_neg();
      n_vec++;
      if (ibus_cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_fresh_cmd: got irdy=%b want 1", ibus_cmd_ready);
      end
      to_next();
      ibus_cmd_valid = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_0001;
      to_neg();
      n_vec++;
      if ({ibus_rsp_valid, ibus_rsp_data} !== {1'b1, 32'hCAFE_0001}) begin
         n_err++;
         $display("FAIL midrst_fresh_rsp: got v=%b data=%h want 1 cafe0001", ibus_rsp_valid, ibus_rsp_data);
      end
      to_next();
      idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         reset             = ($urandom_range(0, 199) != 0);
         ibus_cmd_valid    = $urandom_range(0, 1);
         ibus_cmd_address  = $urandom;
         ibus_cmd_size     = 3'($urandom_range(0, 6));
         dbus_cmd_valid    = $urandom_range(0, 1);
         dbus_cmd_wr       = $urandom_range(0, 1);
         dbus_cmd_uncached = $urandom_range(0, 1);
         dbus_cmd_last     = $urandom_range(0, 1);
         dbus_cmd_address  = $urandom;
         dbus_cmd_data     = $urandom;
         dbus_cmd_mask     = 4'($urandom);
         dbus_cmd_size     = 3'($urandom_range(0, 6));
         mem_cmd_ready     = ($urandom_range(0, 3) != 0);
         mem_rsp_valid     = $urandom_range(0, 1);
         mem_rsp_data      = $urandom;
         mem_rsp_error     = $urandom_range(0, 1);
         to_neg();
         n_vec++;
         if (mem_cmd_valid !== e_mvld) begin
            n_err++;
            $display("FAIL rnd_mvld c%0d: got %b want %b", c, mem_cmd_valid, e_mvld);
         end
         if (e_mvld) begin
            n_vec++;
            if ({mem_cmd_src, mem_cmd_wr, mem_cmd_uncached, mem_cmd_last, mem_cmd_address,
                 mem_cmd_data, mem_cmd_mask, mem_cmd_size} !== e_cmd) begin
               n_err++;
               $display("FAIL rnd_cmd c%0d: got %h want %h", c,
                        {mem_cmd_src, mem_cmd_wr, mem_cmd_uncached, mem_cmd_last, mem_cmd_address,
                         mem_cmd_data, mem_cmd_mask, mem_cmd_size}, e_cmd);
            end
         end
         if (ibus_cmd_valid) begin
            n_vec++;
            if (ibus_cmd_ready !== e_irdy) begin
               n_err++;
               $display("FAIL rnd_irdy c%0d: got %b want %b", c, ibus_cmd_ready, e_irdy);
            end
         end
         if (dbus_cmd_valid) begin
            n_vec++;
            if (dbus_cmd_ready !== e_drdy) begin
               n_err++;
               $display("FAIL rnd_drdy c%0d: got %b want %b", c, dbus_cmd_ready, e_drdy);
            end
         end
         n_vec++;
         if ({ibus_rsp_valid, dbus_rsp_valid, dbus_rsp_last} !== {e_irsp, e_drsp, e_dlast}) begin
            n_err++;
            $display("FAIL rnd_rsp c%0d: got i/d/last=%b want %b", c,
                     {ibus_rsp_valid, dbus_rsp_valid, dbus_rsp_last}, {e_irsp, e_drsp, e_dlast});
         end
         if (e_irsp || e_drsp) begin
            n_vec++;
            if ((e_irsp ? {ibus_rsp_data, ibus_rsp_error} : {dbus_rsp_data, dbus_rsp_error})
                !== {mem_rsp_data, mem_rsp_error}) begin
               n_err++;
               $display("FAIL rnd_rsp_data c%0d: got i=%h d=%h want %h", c,
                        {ibus_rsp_data, ibus_rsp_error}, {dbus_rsp_data, dbus_rsp_error},
                        {mem_rsp_data, mem_rsp_error});
            end
         end
         to_next();
      end
      reset = 1;
      idle();
   endtask

   initial begin
      reset = 0;
      idle();
      m_last = 1'b1; m_lock = 0; m_hold = 0; m_hold_src = 0; m_beat = 0;
      test_reset();
      test_single_read();
      test_tie();
      test_write_lock();
      test_outstanding();
      test_hold();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vex_bus_arbiter.md
Name: vex_bus_arbiter

Overview:
- Merges the VexRiscv instruction bus (iBus) and data bus (dBus) onto one shared memory command/response port.
- Round-robin arbitration on commands; dBus write bursts are locked until their last beat.
- A source-tag FIFO records every outstanding read, so in-order memory responses are routed back to the requester that issued them.
- Sits between the VexRiscv core wrapper and the memory/interconnect model in the bench and SoC top.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data beat width (bytes per beat BPB = DATA_W/8)
- MAX_OUTSTANDING, 4, max read commands awaiting completion (power of 2, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- ibus_cmd_valid / ibus_cmd_ready  in / out  1 / 1  iBus command handshake
- ibus_cmd_address / ibus_cmd_size  in  ADDR_W / 3  read address; log2 bytes
- ibus_rsp_valid / ibus_rsp_data / ibus_rsp_error  out  1 / DATA_W / 1  iBus response beat
- dbus_cmd_valid / dbus_cmd_ready  in / out  1 / 1  dBus command handshake
- dbus_cmd_wr, dbus_cmd_uncached, dbus_cmd_last  in  1 each  write; uncached; last write beat
- dbus_cmd_address / dbus_cmd_data / dbus_cmd_mask / dbus_cmd_size  in  ADDR_W / DATA_W / DATA_W/8 / 3
- dbus_rsp_valid, dbus_rsp_last, dbus_rsp_error  out  1 each
- dbus_rsp_data  out  DATA_W
- mem_cmd_valid / mem_cmd_ready  out / in  1 / 1
- mem_cmd_wr, mem_cmd_uncached, mem_cmd_last  out  1 each
- mem_cmd_address / mem_cmd_data / mem_cmd_mask / mem_cmd_size  out  ADDR_W / DATA_W / DATA_W/8 / 3
- mem_cmd_src  out  1  0 = iBus, 1 = dBus
- mem_rsp_valid / mem_rsp_data / mem_rsp_error  in  1 / DATA_W / 1  in-order read beats, no backpressure

Behaviour:
- Reset (reset = 0 at a clk edge):
  - FIFO emptied, beat counter = 0, lock = 0, hold = 0.
  - last_grant = dBus, so the first tie goes to iBus.
  - While reset = 0, every valid and ready output is 0.
  - Reset mid-burst or mid-response drops all in-flight state; mem_rsp_valid arriving with an empty FIFO is ignored.
- Grant selection (combinational when not held or locked):
  - One requester valid: that requester.
  - Both valid: the one not equal to last_grant.
- Hold: if mem_cmd_valid = 1 and mem_cmd_ready = 0, the grant is registered and held the following cycles until the command is accepted. mem_cmd_* stay stable while held (the requesters hold their payloads).
- Lock: a dBus write beat accepted with last = 0 sets lock = dBus. Only dBus is granted until a write beat with last = 1 is accepted. iBus waits.
- Command path is zero latency:
  - mem_cmd_* = granted requester's fields; iBus drives wr = 0, mask = all ones, last = 1, uncached = 0, data = 0.
  - Granted cmd_ready = mem_cmd_ready & !block; the other requester's ready = 0.
  - block = read command & (fifo count == MAX_OUTSTANDING). The block uses the registered count: no same-cycle pop credit. Writes are never blocked.
  - mem_cmd_valid never depends on mem_cmd_ready.
- last_grant updates on each accepted beat with last = 1.
- Outstanding FIFO:
  - On an accepted read, push {src, beats}, where beats = max(1, 2^size / BPB). size is clipped so beats ≤ 8.
  - Writes push nothing and produce no response.
- Response path is zero latency:
  - mem_rsp_valid is routed to the source at the FIFO head; data and error pass through.
  - Beat counter increments per beat. When it reaches head.beats - 1, pop and clear the counter. dbus_rsp_last = 1 on that beat.
  - Push and pop in the same cycle are legal; count is unchanged.
- Error beats count as normal beats; no early termination.

Decomposition:
- Package vex_bus_pkg:
  - typedef src_e {SRC_IBUS = 0, SRC_DBUS = 1}
  - typedef struct outst_t {src_e src; logic [3:0] beats;}
  - function beats_of(size, BPB)
- One sub-module, vex_bus_tag_fifo: a synchronous FIFO of outst_t with depth MAX_OUTSTANDING, full/empty/count outputs, and the same reset.

Test Plan:
- Single read: after reset, iBus read at 0x8000_0000, size 5 → mem_cmd_src = 0 in the same cycle; 8 mem beats → 8 ibus_rsp_valid, no dbus_rsp_valid, FIFO empty afterwards.
- Tie: iBus and dBus reads valid together after reset → iBus accepted in cycle 0, dBus in cycle 1. Response beats for iBus (size 2) then dBus (size 2) route in order; dbus_rsp_last = 1 on the dBus beat.
- Write lock: dBus 4-beat write (last only on beat 4) with iBus valid throughout → 4 consecutive dBus grants, iBus accepted in the cycle after beat 4, zero responses for the write.
- Outstanding limit: 4 size-2 reads accepted → both cmd_ready = 0 with a 5th read pending. The cycle after the first response beat, ready = 1 again.
- Hold: mem_cmd_ready = 0 for 3 cycles with iBus granted, dBus asserting valid in cycle 1 → src stays 0 and the payload is stable; dBus is granted in the cycle after acceptance.
- Reset mid-response: reset = 0 during beat 3 of 8 → all outputs 0, count = 0; later stray mem_rsp beats produce no outputs; a fresh single read completes normally.
